// File: rtl/api_spi_chain.sv
// Serial engine between the API TX/RX FIFOs and a chain of miner channels.
// Visits each enabled channel in turn, exchanging word_num words and then strobing its load line.
module api_spi_chain #(
    parameter int CH_NUM = 16,
    parameter int WORD_W = 32,
    parameter int DIV_W  = 8,
    parameter int CH_W   = 4
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic              start,
    input  logic [CH_NUM-1:0] ch_mask,
    input  logic [DIV_W-1:0]  sck_div,
    input  logic [7:0]        word_num,
    input  logic              tx_avail,
    input  logic [WORD_W-1:0] tx_dout,
    output logic              tx_rd_en,
    input  logic              rx_space,
    output logic              rx_wr_en,
    output logic [WORD_W-1:0] rx_din,
    output logic [CH_W-1:0]   ch_id,
    output logic [CH_NUM-1:0] load,
    output logic              sck,
    output logic              mosi,
    input  logic [CH_NUM-1:0] miso,
    output logic              busy,
    output logic              done
);

    localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CH_NUM-1:0] ONE_HOT0 = {{(CH_NUM-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE, SEL, WAIT, SHIFT, LOAD, GAP} state_t;

    state_t              state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [CH_NUM-1:0]   mask_q, mask_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [7:0]          wn_q, wn_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic                ph_q, ph_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [7:0]          word_q, word_d;
    logic                done_q, done_d;
    logic [WORD_W-1:0]   sh_q, sh_d;
    logic [WORD_W-1:0]   cap_q, cap_d;

    logic phase_end;
    logic last_ch;

    assign phase_end = (cnt_q == div_q);
    assign last_ch   = (ch_q == CH_W'(CH_NUM - 1));
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign ch_id     = ch_q;

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        mask_d   = mask_q;
        div_d    = div_q;
        wn_d     = wn_q;
        cnt_d    = cnt_q;
        ph_d     = ph_q;
        bit_d    = bit_q;
        word_d   = word_q;
        done_d   = 1'b0;
        sh_d     = sh_q;
        cap_d    = cap_q;
        tx_rd_en = 1'b0;
        rx_wr_en = 1'b0;
        rx_din   = '0;
        sck      = 1'b0;
        mosi     = 1'b0;
        load     = '0;

        case (state_q)
            IDLE: begin
                // A start coinciding with the done pulse belongs to the pass just finished.
                if (start && !done_q) begin
                    mask_d = ch_mask;
                    div_d  = sck_div;
                    wn_d   = word_num;
                    ch_d   = '0;
                    if (word_num == 8'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = SEL;
                    end
                end
            end
            SEL: begin
                if (mask_q[ch_q]) begin
                    state_d = WAIT;
                end else if (last_ch) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    ch_d = ch_q + CH_W'(1);
                end
            end
            WAIT: begin
                if (tx_avail && rx_space) begin
                    tx_rd_en = 1'b1;
                    sh_d     = tx_dout;
                    cnt_d    = '0;
                    ph_d     = 1'b0;
                    bit_d    = '0;
                    word_d   = 8'd0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                sck  = ph_q;
                mosi = sh_q[WORD_W-1];
                if (!phase_end) begin
                    cnt_d = cnt_q + DIV_W'(1);
                end else begin
                    cnt_d = '0;
                    if (!ph_q) begin
                        ph_d = 1'b1;
                    end else begin
                        // Last clock of the high phase: sample and advance to the next bit.
                        ph_d  = 1'b0;
                        cap_d = {cap_q[WORD_W-2:0], miso[ch_q]};
                        sh_d  = sh_q << 1;
                        if (bit_q == BIT_W'(WORD_W - 1)) begin
                            bit_d    = '0;
                            rx_wr_en = 1'b1;
                            rx_din   = cap_d;
                            word_d   = word_q + 8'd1;
                            if (word_q == wn_q - 8'd1) begin
                                state_d = LOAD;
                            end else begin
                                tx_rd_en = 1'b1;
                                sh_d     = tx_dout;
                            end
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end
                end
            end
            LOAD: begin
                load = ONE_HOT0 << ch_q;
                if (!phase_end) begin
                    cnt_d = cnt_q + DIV_W'(1);
                end else begin
                    cnt_d = '0;
                    if (!ph_q) begin
                        ph_d = 1'b1;
                    end else begin
                        ph_d    = 1'b0;
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (last_ch) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    ch_d    = ch_q + CH_W'(1);
                    state_d = SEL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q <= IDLE;
            ch_q    <= '0;
            mask_q  <= '0;
            div_q   <= '0;
            wn_q    <= 8'd0;
            cnt_q   <= '0;
            ph_q    <= 1'b0;
            bit_q   <= '0;
            word_q  <= 8'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            mask_q  <= mask_d;
            div_q   <= div_d;
            wn_q    <= wn_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            bit_q   <= bit_d;
            word_q  <= word_d;
            done_q  <= done_d;
        end
    end

    // Shift and capture registers only reach the outputs through gated paths.
    always_ff @(posedge CLK_I) begin
        sh_q  <= sh_d;
        cap_q <= cap_d;
    end

endmodule

// File: tb/tb_api_spi_chain.sv
// Randomized bench for api_spi_chain: FIFO and slave models plus a pass-level reference model.
module tb_api_spi_chain;

    localparam int CH_NUM = 16;
    localparam int WORD_W = 32;
    localparam int DIV_W  = 8;
    localparam int CH_W   = 4;

    logic              CLK_I = 1'b0;
    logic              RST_I = 1'b1;
    logic              start = 1'b0;
    logic [CH_NUM-1:0] ch_mask = '0;
    logic [DIV_W-1:0]  sck_div = '0;
    logic [7:0]        word_num = 8'd0;
    logic              tx_avail = 1'b0;
    logic [WORD_W-1:0] tx_dout = '0;
    logic              tx_rd_en;
    logic              rx_space = 1'b1;
    logic              rx_wr_en;
    logic [WORD_W-1:0] rx_din;
    logic [CH_W-1:0]   ch_id;
    logic [CH_NUM-1:0] load;
    logic              sck;
    logic              mosi;
    logic [CH_NUM-1:0] miso;
    logic              busy;
    logic              done;
    logic [CH_NUM-1:0] inv = '0;

    // Each slave loops mosi back, optionally inverted per channel so channel mix-ups show up.
    assign miso = {CH_NUM{mosi}} ^ inv;

    api_spi_chain #(.CH_NUM(CH_NUM), .WORD_W(WORD_W), .DIV_W(DIV_W), .CH_W(CH_W)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .start(start), .ch_mask(ch_mask), .sck_div(sck_div),
        .word_num(word_num), .tx_avail(tx_avail), .tx_dout(tx_dout), .tx_rd_en(tx_rd_en),
        .rx_space(rx_space), .rx_wr_en(rx_wr_en), .rx_din(rx_din), .ch_id(ch_id), .load(load),
        .sck(sck), .mosi(mosi), .miso(miso), .busy(busy), .done(done)
    );

    always #5 CLK_I = ~CLK_I;

    logic [WORD_W-1:0] txq[$];
    logic [WORD_W-1:0] infl[$];
    logic [WORD_W-1:0] preset[$];
    int expch[$];
    int ld_ch[$];
    int ld_w[$];

    int total = 0, bad = 0, cyc = 0;
    int n_pop, n_wr, n_done, n_sck, n_busy, done_cyc, start_cyc, busy_at1;
    int phase_bad, mosi_bad, misc_bad, run, ld_len;
    int d_cur = 0, wn_cur = 0;
    bit start_seen, hi_seen, load_since, pop_pend, tx_ok;
    logic sck_prev = 1'b0, mosi_prev = 1'b0, rd_prev = 1'b0, wr_prev = 1'b0;
    logic [CH_NUM-1:0] load_prev = '0;
    logic [63:0] snap;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int oh_idx(input logic [CH_NUM-1:0] v);
        int r = -1;
        for (int i = 0; i < CH_NUM; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic clear();
        txq.delete(); infl.delete(); expch.delete(); ld_ch.delete(); ld_w.delete();
        n_pop = 0; n_wr = 0; n_done = 0; n_sck = 0; n_busy = 0; done_cyc = -1;
        start_cyc = -1; busy_at1 = 0; phase_bad = 0; mosi_bad = 0; misc_bad = 0;
        run = 0; ld_len = 0; start_seen = 0; hi_seen = 0; load_since = 0; pop_pend = 0;
    endtask

    // One clock: models and monitor act at the falling edge, drivers resume after the rising edge.
    task automatic tick();
        int e_ch;
        logic [WORD_W-1:0] ew;
        @(negedge CLK_I);
        cyc++;
        if (pop_pend && txq.size() > 0) void'(txq.pop_front());
        pop_pend = 0;
        tx_dout  = (txq.size() > 0) ? txq[0] : '0;
        tx_avail = tx_ok && (txq.size() >= wn_cur);
        #1;
        snap = 64'({sck, mosi, load, tx_rd_en, rx_wr_en, busy, done, rx_din, ch_id});
        if (start && !start_seen) begin start_seen = 1; start_cyc = cyc; end
        if (start_seen && cyc == start_cyc + 1) busy_at1 = int'(busy);
        if (busy) n_busy++;
        if (sck) n_sck++;
        if (busy && !rx_space && (sck || tx_rd_en)) misc_bad++;
        if (tx_rd_en) begin n_pop++; infl.push_back(tx_dout); pop_pend = 1; end
        if (rx_wr_en) begin
            n_wr++;
            if (wr_prev) misc_bad++;
            if (expch.size() == 0 || infl.size() == 0) begin
                check("rx_extra", 64'(n_wr), 64'(0));
            end else begin
                e_ch = expch.pop_front();
                ew   = infl.pop_front() ^ {WORD_W{inv[e_ch]}};
                check("rx_word", 64'(rx_din), 64'(ew));
                check("rx_ch_id", 64'(ch_id), 64'(e_ch));
            end
        end
        wr_prev = rx_wr_en;
        if (done) begin n_done++; done_cyc = cyc; if (busy) misc_bad++; end
        if (sck == sck_prev) run++;
        else begin
            if (sck_prev) begin
                if (run != d_cur + 1) phase_bad++;
                hi_seen = 1;
            end else if (hi_seen && !load_since) begin
                if (run != d_cur + 1) phase_bad++;
            end
            if (sck) load_since = 0;
            run = 1;
        end
        if (mosi !== mosi_prev && !(sck_prev && !sck) && !rd_prev) mosi_bad++;
        mosi_prev = mosi; rd_prev = tx_rd_en; sck_prev = sck;
        if (load != '0 && load != load_prev) begin
            ld_ch.push_back(oh_idx(load));
            ld_len = 1;
            if (!$onehot(load)) misc_bad++;
        end else if (load != '0) ld_len++;
        if (load == '0 && load_prev != '0) ld_w.push_back(ld_len);
        if (load != '0) load_since = 1;
        load_prev = load;
        @(posedge CLK_I);
        #1;
    endtask

    // mode 1: extra start while busy; mode 2: start held for two cycles.
    task automatic run_pass(input logic [CH_NUM-1:0] m, input int d, input int wn,
                            input int stall, input int mode);
        int en_list[$];
        int exp_len, exp_gap, en, f;
        clear();
        inv = (preset.size() != 0) ? '0 : CH_NUM'($urandom);
        exp_len = 0; f = -1;
        if (wn > 0) begin
            for (int c = 0; c < CH_NUM; c++) begin
                if (m[c]) begin
                    en_list.push_back(c);
                    if (f < 0) f = c;
                    exp_len += 3 + wn * WORD_W * 2 * (d + 1) + 2 * (d + 1);
                    for (int k = 0; k < wn; k++) begin
                        expch.push_back(c);
                        txq.push_back((preset.size() != 0) ? preset.pop_front() : WORD_W'($urandom));
                    end
                end else begin
                    exp_len += 1;
                end
            end
        end
        en = en_list.size();
        exp_gap = (wn == 0) ? 1 : exp_len + stall + 1;
        d_cur = d; wn_cur = wn; tx_ok = 1; rx_space = (stall == 0);
        ch_mask = m; sck_div = DIV_W'(d); word_num = 8'(wn); start = 1'b1;
        tick();
        if (mode != 2) start = 1'b0;
        tick();
        start = 1'b0;
        if (mode == 1) begin
            ch_mask = ~m; word_num = 8'(wn + 1); sck_div = DIV_W'(d + 1); start = 1'b1;
            tick();
            start = 1'b0; ch_mask = m; word_num = 8'(wn); sck_div = DIV_W'(d);
        end
        if (stall > 0) begin
            while (cyc + 1 < start_cyc + f + 2 + stall) tick();
            check("bp_pops", 64'(n_pop), 64'(0));
            check("bp_sck", 64'(n_sck), 64'(0));
            rx_space = 1'b1;
        end
        for (int i = 0; i < 30000 && n_done == 0; i++) tick();
        repeat (4) tick();
        check("done_cnt", 64'(n_done), 64'(1));
        check("pass_len", 64'(done_cyc - start_cyc), 64'(exp_gap));
        check("busy_t1", 64'(busy_at1), 64'((wn > 0) ? 1 : 0));
        check("tx_pops", 64'(n_pop), 64'(wn * en));
        check("rx_wrs", 64'(n_wr), 64'(wn * en));
        check("load_cnt", 64'(ld_ch.size()), 64'(en));
        for (int i = 0; i < ld_ch.size() && i < en; i++) begin
            check("load_ch", 64'(ld_ch[i]), 64'(en_list[i]));
            check("load_len", 64'((i < ld_w.size()) ? ld_w[i] : -1), 64'(2 * (d + 1)));
        end
        check("sck_phase", 64'(phase_bad), 64'(0));
        check("mosi_stable", 64'(mosi_bad), 64'(0));
        check("protocol", 64'(misc_bad), 64'(0));
        if (wn == 0) begin
            check("no_sck", 64'(n_sck), 64'(0));
            check("no_busy", 64'(n_busy), 64'(0));
        end
        tx_ok = 0;
    endtask

    task automatic reset_mid_shift();
        clear();
        inv = '0; d_cur = 0; wn_cur = 2; tx_ok = 1; rx_space = 1'b1;
        txq.push_back(WORD_W'($urandom)); txq.push_back(WORD_W'($urandom));
        expch.push_back(0); expch.push_back(0);
        ch_mask = 16'h0001; sck_div = '0; word_num = 8'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2000 && n_wr < 1; i++) tick();
        repeat (20) tick();
        RST_I = 1'b1;
        tick();
        RST_I = 1'b0;
        tick();
        check("rst_outputs", snap, 64'(0));
        repeat (300) tick();
        check("rst_no_wr", 64'(n_wr), 64'(1));
        check("rst_no_done", 64'(n_done), 64'(0));
        tx_ok = 0;
    endtask

    initial begin
        @(posedge CLK_I);
        #1;
        repeat (3) tick();
        check("reset_state", snap, 64'(0));
        RST_I = 1'b0;
        tick();

        preset.push_back(32'hA5A5A5A5); preset.push_back(32'h0000FFFF);
        run_pass(16'h0001, 0, 2, 0, 0);
        run_pass(16'h8001, 0, 1, 0, 0);
        run_pass(16'h0006, 3, 1, 0, 0);
        run_pass(16'h0010, 1, 1, 50, 0);
        reset_mid_shift();
        run_pass(16'h0003, 0, 2, 0, 0);
        run_pass(16'hFFFF, 0, 0, 0, 2);
        run_pass(16'h0101, 0, 1, 0, 1);
        for (int p = 0; p < 5; p++)
            run_pass(CH_NUM'($urandom), $urandom_range(0, 2), $urandom_range(1, 2), 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
